// File: rtl/ccd_cmd_pkg.sv
// Shared types and constants for the UART command receiver of the CCD capture chain.
// Frame FSM / byte-receiver state encodings plus the command-frame byte values.
package ccd_cmd_pkg;

  typedef enum logic [2:0] {
    F_IDLE = 3'd0,
    F_CMD  = 3'd1,
    F_DHI  = 3'd2,
    F_DLO  = 3'd3,
    F_CSUM = 3'd4,
    F_EXEC = 3'd5
  } frame_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] HDR_BYTE     = 8'hA5;
  localparam logic [7:0] OP_SET_INTEG = 8'h01;
  localparam logic [7:0] OP_START     = 8'h02;
  localparam logic [7:0] OP_STREAM    = 8'h03;

  // Integration time must never drop below one full line readout.
  function automatic logic [15:0] clamp_min(input logic [15:0] value,
                                            input logic [15:0] floor_val);
    return (value < floor_val) ? floor_val : value;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Bit-level 8N1 UART receiver: 2-FF synchroniser, baud counter, start-glitch and stop checks.
// byte_valid / frame_err are one-cycle strobes with no ready: rx_data must be taken in the strobe cycle.
module uart_rx_byte
  import ccd_cmd_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
  localparam int HALF_CNT = BPS_CNT / 2;
  localparam int CNT_W    = $clog2(BPS_CNT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);

  rx_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_idx_next;
  logic [7:0]       shift, shift_next;
  logic             valid_next, err_next;
  logic             rxd_s1, rxd_s2, rxd_d;
  logic             fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign fall    = rxd_d & ~rxd_s2;
  assign rx_data = shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      byte_valid <= valid_next;
      frame_err  <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_next = '0;
        if (fall) state_next = RX_START;
      end
      RX_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rxd_s2 ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd_s2, shift[7:1]};
          if (bit_idx == 3'd7) state_next = RX_STOP;
          else bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      RX_STOP: begin
        // Re-arm at mid stop bit so a back-to-back start edge is not missed.
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          valid_next = rxd_s2;
          err_next   = ~rxd_s2;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Host->board command path: UART byte receiver plus frame FSM driving CCD/uplink controls.
// Define CMD_CHECKSUM_EN for 5-byte frames carrying a trailing (CMD+D_HI+D_LO) mod 256 checksum.
module uart_cmd_rx
  import ccd_cmd_pkg::*;
#(
  parameter int          CLK_FREQ     = 50_000_000,
  parameter int          UART_BPS     = 115200,
  parameter logic [15:0] DEF_INTEG    = 16'd1000,
  parameter logic [15:0] MIN_INTEG    = 16'd130,
  parameter int          TIMEOUT_BITS = 20
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_rxd,
  output logic [15:0] integ_time,
  output logic        ccd_start,
  output logic        stream_en,
  output logic        cmd_valid,
  output logic        cmd_err
);

  localparam int BPS_CNT    = CLK_FREQ / UART_BPS;
  localparam int TMO_CYCLES = TIMEOUT_BITS * BPS_CNT;
  localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES);

  logic [7:0] rx_data;
  logic       byte_valid, frame_err;

  uart_rx_byte #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) u_rx (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .rxd       (uart_rxd),
    .rx_data   (rx_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  frame_state_t     state, state_next;
  logic [7:0]       op_q, dhi_q;
  logic [TMO_W-1:0] tmo_cnt;
  logic [15:0]      exec_data;
  logic             in_frame, frame_done, csum_ok, abort, op_known, exec_ok;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]       dlo_q, csum_acc;
`endif

  assign in_frame = (state == F_CMD) || (state == F_DHI) ||
                    (state == F_DLO) || (state == F_CSUM);
  assign op_known = (op_q == OP_SET_INTEG) || (op_q == OP_START) || (op_q == OP_STREAM);
  assign exec_ok  = frame_done & csum_ok & op_known;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= F_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    csum_ok    = 1'b1;
    abort      = 1'b0;
`ifdef CMD_CHECKSUM_EN
    exec_data  = {dhi_q, dlo_q};
`else
    exec_data  = {dhi_q, rx_data};
`endif
    case (state)
      F_IDLE: begin
        if (byte_valid && (rx_data == HDR_BYTE)) state_next = F_CMD;
      end
      F_EXEC: begin
        state_next = F_IDLE;
        abort      = frame_err;
      end
      default: begin
        // Inside a frame every byte is payload, including 0xA5.
        if (frame_err || (!byte_valid && (tmo_cnt == TMO_LAST))) begin
          abort      = 1'b1;
          state_next = F_IDLE;
        end else if (byte_valid) begin
          case (state)
            F_CMD: state_next = F_DHI;
            F_DHI: state_next = F_DLO;
`ifdef CMD_CHECKSUM_EN
            F_DLO: state_next = F_CSUM;
            F_CSUM: begin
              state_next = F_EXEC;
              frame_done = 1'b1;
              csum_ok    = (rx_data == csum_acc);
            end
`else
            F_DLO: begin
              state_next = F_EXEC;
              frame_done = 1'b1;
            end
`endif
            default: state_next = F_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op_q     <= '0;
      dhi_q    <= '0;
      tmo_cnt  <= '0;
`ifdef CMD_CHECKSUM_EN
      dlo_q    <= '0;
      csum_acc <= '0;
`endif
    end else begin
      if (byte_valid) begin
        case (state)
          F_CMD: op_q  <= rx_data;
          F_DHI: dhi_q <= rx_data;
`ifdef CMD_CHECKSUM_EN
          F_DLO: dlo_q <= rx_data;
`endif
          default: ;
        endcase
`ifdef CMD_CHECKSUM_EN
        if (state == F_CMD) csum_acc <= rx_data;
        else if ((state == F_DHI) || (state == F_DLO)) csum_acc <= csum_acc + rx_data;
`endif
      end
      // Gap counter restarts on every received byte and saturates at the limit.
      if (!in_frame || byte_valid) tmo_cnt <= '0;
      else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end

  // All effects land in the EXEC cycle, one clock after the last byte_valid.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      integ_time <= DEF_INTEG;
      stream_en  <= 1'b0;
      ccd_start  <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      cmd_valid <= exec_ok;
      cmd_err   <= abort | (frame_done & ~(csum_ok & op_known));
      ccd_start <= exec_ok & (op_q == OP_START);
      if (exec_ok && (op_q == OP_SET_INTEG)) integ_time <= clamp_min(exec_data, MIN_INTEG);
      if (exec_ok && (op_q == OP_STREAM))    stream_en  <= exec_data[0];
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed self-checking bench for uart_cmd_rx; runs a fast baud (16 clocks/bit) to keep runtime short.
// Works with or without CMD_CHECKSUM_EN; checksum-specific vectors are selected by the same macro.
module tb_uart_cmd_rx;

  localparam int CLK_FREQ = 50_000_000;
  localparam int UART_BPS = 3_125_000;
  localparam int BIT      = CLK_FREQ / UART_BPS;
  localparam logic [1:0] EV_OK  = 2'd1;
  localparam logic [1:0] EV_ERR = 2'd2;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        uart_rxd;
  logic [15:0] integ_time;
  logic        ccd_start, stream_en, cmd_valid, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_bv_cyc = 0;
  int n_start  = 0;
  int n_evt    = 0;
  int snap;
  logic [1:0] ev;
  logic [1:0] exp_q[$];

  uart_cmd_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .UART_BPS    (UART_BPS),
    .DEF_INTEG   (16'd1000),
    .MIN_INTEG   (16'd130),
    .TIMEOUT_BITS(20)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .uart_rxd  (uart_rxd),
    .integ_time(integ_time),
    .ccd_start (ccd_start),
    .stream_en (stream_en),
    .cmd_valid (cmd_valid),
    .cmd_err   (cmd_err)
  );

  // Clock and watchdog
  always #10 sys_clk = ~sys_clk;

  initial begin
    repeat (60_000) @(posedge sys_clk);
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every cmd_valid/cmd_err pulse must match the next expected event.
  always @(negedge sys_clk) begin
    cyc++;
    if (sys_rst_n) begin
      if (dut.u_rx.byte_valid) last_bv_cyc = cyc;
      if (ccd_start) n_start++;
      if (cmd_valid || cmd_err) begin
        n_evt++;
        check("pulse_exclusive", 32'(cmd_valid & cmd_err), 32'd0);
        if (cmd_valid) check("valid_latency", 32'(cyc - last_bv_cyc), 32'd1);
        ev = cmd_valid ? EV_OK : EV_ERR;
        if (exp_q.size() == 0) check("unexpected_event", 32'(ev), 32'd0);
        else check("event", 32'(ev), 32'(exp_q.pop_front()));
      end
    end
  end

  // Driver tasks
  task automatic idle_bits(input int n);
    uart_rxd = 1'b1;
    repeat (n * BIT) @(posedge sys_clk);
  endtask

  task automatic settle();
    idle_bits(2);
    check("pending_events", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (BIT) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (BIT) @(posedge sys_clk);
    end
    uart_rxd = stop_bit;
    repeat (BIT) @(posedge sys_clk);
    uart_rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] dhi, input logic [7:0] dlo);
    logic [7:0] sum;
    sum = op + dhi + dlo;
    send_byte(8'hA5, 1'b1);
    send_byte(op, 1'b1);
    send_byte(dhi, 1'b1);
    send_byte(dlo, 1'b1);
`ifdef CMD_CHECKSUM_EN
    send_byte(sum, 1'b1);
`else
    sum = 8'h00;
`endif
    settle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_integ"}, 32'(integ_time), 32'd1000);
    check({tag, "_stream"}, 32'(stream_en), 32'd0);
    check({tag, "_start"}, 32'(ccd_start), 32'd0);
    check({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_err"}, 32'(cmd_err), 32'd0);
  endtask

  initial begin
    uart_rxd  = 1'b1;
    sys_rst_n = 1'b0;
    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs("reset");
    sys_rst_n = 1'b1;
    idle_bits(2);

    // Set integration time, including the default value and a non-default one.
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h03, 8'hE8);
    check("integ_1000", 32'(integ_time), 32'd1000);
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h12, 8'h34);
    check("integ_1234", 32'(integ_time), 32'h1234);

    // Clamp boundary: 16 and 129 clamp to 130, 131 passes through.
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h00, 8'h10);
    check("integ_clamp16", 32'(integ_time), 32'd130);
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h00, 8'h81);
    check("integ_clamp129", 32'(integ_time), 32'd130);
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h00, 8'h83);
    check("integ_131", 32'(integ_time), 32'd131);

    // Single capture trigger.
    snap = n_start;
    exp_q.push_back(EV_OK);
    send_frame(8'h02, 8'h00, 8'h00);
    check("start_pulses", 32'(n_start - snap), 32'd1);
    check("integ_after_start", 32'(integ_time), 32'd131);

    // Rejected frame leaves stream_en alone; valid STREAM frames set then clear it.
`ifdef CMD_CHECKSUM_EN
    exp_q.push_back(EV_ERR);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    settle();
`else
    exp_q.push_back(EV_ERR);
    send_frame(8'h07, 8'h00, 8'h01);
`endif
    check("stream_after_reject", 32'(stream_en), 32'd0);
    exp_q.push_back(EV_OK);
    send_frame(8'h03, 8'h00, 8'h01);
    check("stream_on", 32'(stream_en), 32'd1);
    exp_q.push_back(EV_OK);
    send_frame(8'h03, 8'h00, 8'h02);
    check("stream_off", 32'(stream_en), 32'd0);

    // Short start glitch, framing error and junk byte in IDLE: all silent.
    snap = n_evt;
    uart_rxd = 1'b0;
    repeat (BIT / 4) @(posedge sys_clk);
    idle_bits(3);
    check("glitch_silent", 32'(n_evt - snap), 32'd0);
    send_byte(8'h33, 1'b0);
    idle_bits(2);
    check("idle_ferr_silent", 32'(n_evt - snap), 32'd0);
    send_byte(8'h5A, 1'b1);
    idle_bits(2);
    check("junk_silent", 32'(n_evt - snap), 32'd0);

    // Framing error after the header aborts; next frame parses from IDLE.
    exp_q.push_back(EV_ERR);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    settle();
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h00, 8'hC8);
    check("integ_after_ferr", 32'(integ_time), 32'd200);

    // 0xA5 inside a frame is plain data.
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'hA5, 8'hA5);
    check("integ_a5a5", 32'(integ_time), 32'hA5A5);

    // Inter-byte timeout, then a normal frame.
    exp_q.push_back(EV_ERR);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    idle_bits(25);
    check("timeout_pending", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(EV_OK);
    send_frame(8'h03, 8'h00, 8'h01);
    check("stream_after_tmo", 32'(stream_en), 32'd1);
    check("integ_after_tmo", 32'(integ_time), 32'hA5A5);

    // Reset asserted in the middle of D_HI.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    uart_rxd = 1'b0;
    repeat (3 * BIT) @(posedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(posedge sys_clk);
    uart_rxd = 1'b1;
    @(negedge sys_clk);
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge sys_clk);
    sys_rst_n = 1'b1;
    idle_bits(2);
    exp_q.push_back(EV_OK);
    send_frame(8'h01, 8'h07, 8'hD0);
    check("integ_after_reset", 32'(integ_time), 32'd2000);

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
